// File: rtl/ram_responder_if.sv
// Cache-to-RAM request/acknowledge bundle: the cache (master) issues rd/wr pulses,
// the RAM side (slave) answers with a one-cycle ram_data_valid and read data.
interface ram_responder_if #(
  parameter int ADDRESS_WIDTH = 16
);
  logic [ADDRESS_WIDTH-1:0] ram_address;
  logic                     ram_rd;
  logic                     ram_wr;
  logic [31:0]              ram_data_wr;
  logic [31:0]              ram_data_rd;
  logic                     ram_data_valid;
  logic                     protocol_error;

  modport master (
    output ram_address, ram_rd, ram_wr, ram_data_wr,
    input  ram_data_rd, ram_data_valid, protocol_error
  );

  modport slave (
    input  ram_address, ram_rd, ram_wr, ram_data_wr,
    output ram_data_rd, ram_data_valid, protocol_error
  );
endinterface

// File: rtl/ram_responder.sv
// Word-organised RAM model answering single-cycle rd/wr pulses; RAM_RANDOM_LATENCY_EN adds 0-3 cycles of LFSR jitter.
// Ack READ_LATENCY/WRITE_LATENCY cycles after accept; one request outstanding, requests outside IDLE are dropped and flagged.
module ram_responder #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2,
  parameter int MEM_WORDS     = 2**(ADDRESS_WIDTH-2)
) (
  input  logic           clk,
  input  logic           rst,
  ram_responder_if.slave bus
);
  localparam int IDX_W = ADDRESS_WIDTH - 2;
  localparam int MA_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
`ifdef RAM_RANDOM_LATENCY_EN
  localparam int JITTER = 3;
`else
  localparam int JITTER = 0;
`endif
  localparam int MAX_LAT = ((READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY) + JITTER;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [IDX_W:0] DEPTH    = (IDX_W+1)'(MEM_WORDS);
  localparam logic [31:0]    OOR_DATA = 32'hDEAD_BEEF;

  generate
    if (READ_LATENCY < 1 || WRITE_LATENCY < 1) begin : g_bad_latency
      $error("ram_responder: READ_LATENCY and WRITE_LATENCY must be >= 1");
    end
    if (MEM_WORDS < 1 || MEM_WORDS > 2**IDX_W) begin : g_bad_depth
      $error("ram_responder: MEM_WORDS must lie in 1 .. 2**(ADDRESS_WIDTH-2)");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             op_wr, op_wr_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [31:0]      rd_q;
  logic             err_q;
  logic             err_set;
  logic             accept;
  logic             load_rd;
  logic             req;
  logic [IDX_W-1:0] req_idx;
  logic [CNT_W-1:0] lat_sel;
  logic             unused_addr_lsbs;

  logic [31:0] mem [MEM_WORDS];

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < DEPTH);
  endfunction

  assign req              = bus.ram_rd | bus.ram_wr;
  assign req_idx          = bus.ram_address[ADDRESS_WIDTH-1:2];
  assign unused_addr_lsbs = ^bus.ram_address[1:0];

`ifdef RAM_RANDOM_LATENCY_EN
  logic [7:0] lfsr;
  logic       lfsr_fb;

  // Fibonacci taps 8,6,5,4; stepped once per accepted request
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign lat_sel = (bus.ram_wr ? CNT_W'(WRITE_LATENCY) : CNT_W'(READ_LATENCY))
                 + CNT_W'(lfsr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else if (accept) begin
      lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end
`else
  assign lat_sel = bus.ram_wr ? CNT_W'(WRITE_LATENCY) : CNT_W'(READ_LATENCY);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_wr <= 1'b0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_wr <= op_wr_nxt;
      idx_q <= idx_nxt;
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_wr_nxt = op_wr;
    idx_nxt   = idx_q;
    err_set   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept    = 1'b1;
          op_wr_nxt = bus.ram_wr;
          idx_nxt   = req_idx;
          // rd+wr together: the write wins, the read is dropped
          if ((bus.ram_rd && bus.ram_wr) || !in_range(req_idx)) begin
            err_set = 1'b1;
          end
          if (lat_sel == CNT_W'(1)) begin
            state_nxt = RESPOND;
            cnt_nxt   = '0;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = lat_sel - CNT_W'(1);
          end
        end
      end
      WAIT: begin
        err_set = req;
        if (cnt == CNT_W'(1)) begin
          state_nxt = RESPOND;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESPOND: begin
        err_set   = req;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Read data is fetched on the edge that enters RESPOND
  assign load_rd = (state_nxt == RESPOND) && (state != RESPOND) && !op_wr_nxt;

  // Writes commit at accept so a following read sees them; memory is never reset
  always_ff @(posedge clk) begin
    if (!rst && accept && bus.ram_wr && in_range(req_idx)) begin
      mem[req_idx[MA_W-1:0]] <= bus.ram_data_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (load_rd) begin
      rd_q <= in_range(idx_nxt) ? mem[idx_nxt[MA_W-1:0]] : OOR_DATA;
    end
  end

  assign bus.ram_data_rd    = rd_q;
  assign bus.ram_data_valid = (state == RESPOND);
  assign bus.protocol_error = err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed table-driven bench for ram_responder (READ_LATENCY=4, WRITE_LATENCY=2, 256 words).
module tb_ram_responder;
  localparam int AW = 16;
  localparam int BOUND = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_ack = 0;
  logic have_prev = 1'b0;

  ram_responder_if #(.ADDRESS_WIDTH(AW)) bus ();

  ram_responder #(
    .ADDRESS_WIDTH(AW),
    .READ_LATENCY (4),
    .WRITE_LATENCY(2),
    .MEM_WORDS    (256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          rst_before;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    int            extra_at;
    int            exp_lat;
    logic [31:0]   exp_data;
    logic          exp_err;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    check({tag, "_rst_vld"}, {31'd0, bus.ram_data_valid}, 32'd0);
    check({tag, "_rst_rd"},  bus.ram_data_rd, 32'd0);
    check({tag, "_rst_err"}, {31'd0, bus.protocol_error}, 32'd0);
    rst = 1'b0;
    have_prev = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   n;
    logic got;
    if (v.rst_before) do_reset(tag);
    bus.ram_rd      = v.rd;
    bus.ram_wr      = v.wr;
    bus.ram_address = v.addr;
    bus.ram_data_wr = v.wdata;
    @(posedge clk); #1;
    bus.ram_rd = 1'b0;
    bus.ram_wr = 1'b0;
    n   = 1;
    got = 1'b0;
    while (!got && n <= BOUND) begin
      if (bus.ram_data_valid) begin
        got = 1'b1;
      end else begin
        if (n == v.extra_at) begin
          bus.ram_rd      = 1'b1;
          bus.ram_address = 16'h0020;
        end
        @(posedge clk); #1;
        bus.ram_rd = 1'b0;
        n++;
      end
    end
    check({tag, "_lat"}, n, v.exp_lat);
    check({tag, "_data"}, bus.ram_data_rd, v.exp_data);
    check({tag, "_err"}, {31'd0, bus.protocol_error}, {31'd0, v.exp_err});
    if (have_prev) check({tag, "_spacing"}, cyc - last_ack, v.exp_lat + 1);
    last_ack  = cyc;
    have_prev = got;
    @(posedge clk); #1;
    check({tag, "_vld_1cyc"}, {31'd0, bus.ram_data_valid}, 32'd0);
  endtask

  initial begin
    vec_t w;
    //          rstb  rd    wr    addr      wdata          x   lat data           err
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 16'h0010, 32'h1234_5678, -1, 2, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 32'h0,         -1, 4, 32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0013, 32'h0,         -1, 4, 32'h1234_5678, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h0020, 32'hA0A0_0000, -1, 2, 32'h1234_5678, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h0024, 32'hA1A1_1111, -1, 2, 32'h1234_5678, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h0028, 32'hA2A2_2222, -1, 2, 32'h1234_5678, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h002C, 32'hA3A3_3333, -1, 2, 32'h1234_5678, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0020, 32'h0,         -1, 4, 32'hA0A0_0000, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0024, 32'h0,         -1, 4, 32'hA1A1_1111, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0028, 32'h0,         -1, 4, 32'hA2A2_2222, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h002C, 32'h0,         -1, 4, 32'hA3A3_3333, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0010, 32'h0,          2, 4, 32'h1234_5678, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 16'h0040, 32'hCAFE_F00D, -1, 2, 32'h0000_0000, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 16'h0040, 32'h0,         -1, 4, 32'hCAFE_F00D, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 16'h0000, 32'h1111_1111, -1, 2, 32'h0000_0000, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 16'h0400, 32'h2222_2222, -1, 2, 32'h0000_0000, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 16'h0000, 32'h0,         -1, 4, 32'h1111_1111, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 16'h0404, 32'h0,         -1, 4, 32'hDEAD_BEEF, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 16'h0010, 32'h0,         -1, 4, 32'h1234_5678, 1'b1};

    bus.ram_rd      = 1'b0;
    bus.ram_wr      = 1'b0;
    bus.ram_address = '0;
    bus.ram_data_wr = '0;
    @(posedge clk);
    do_reset("init");

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // reset while a read is waiting: its ack must never appear
    bus.ram_rd      = 1'b1;
    bus.ram_address = 16'h0020;
    @(posedge clk); #1;
    bus.ram_rd = 1'b0;
    @(posedge clk); #1;
    check("midrst_wait_vld", {31'd0, bus.ram_data_valid}, 32'd0);
    do_reset("midrst");
    w = '{1'b0, 1'b0, 1'b1, 16'h0030, 32'h55AA_55AA, -1, 2, 32'h0000_0000, 1'b0};
    run_vec(w, "post_rst_wr");
    w = '{1'b0, 1'b1, 1'b0, 16'h0030, 32'h0,         -1, 4, 32'h55AA_55AA, 1'b0};
    run_vec(w, "post_rst_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Word-organised memory model and controller on the RAM side of the cache's external RAM interface.
- Responds to single-cycle read/write request pulses from the cache with a configurable-latency `ram_data_valid` acknowledge.
- Non-pipelined: exactly one outstanding request.
- Used as the backing store under direct-mapped and future caches, both in simulation and in FPGA builds.

Parameters:
- ADDRESS_WIDTH, 16: byte-address width. Must match the cache.
- READ_LATENCY, 4: cycles from accepting a read to `ram_data_valid`. Must be ≥1.
- WRITE_LATENCY, 2: cycles from accepting a write to `ram_data_valid`. Must be ≥1.
- MEM_WORDS, 2**(ADDRESS_WIDTH-2): depth in 32-bit words. Must be ≤ 2**(ADDRESS_WIDTH-2).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- ram_address  input  ADDRESS_WIDTH  byte address of the request; bits [1:0] are ignored
- ram_rd  input  1  read request pulse
- ram_wr  input  1  write request pulse
- ram_data_wr  input  32  write data, sampled with `ram_wr`
- ram_data_rd  output  32  read data, valid while `ram_data_valid` is high after a read
- ram_data_valid  output  1  one-cycle acknowledge for the accepted request
- protocol_error  output  1  sticky flag for a protocol violation

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - `ram_data_valid` = 0, `ram_data_rd` = 0, `protocol_error` = 0.
  - State = IDLE, latency counter = 0.
  - Memory contents are not reset.
- Word index is `ram_address[ADDRESS_WIDTH-1:2]`.
  - Index ≥ MEM_WORDS: the request is still accepted and acknowledged.
  - Such a read returns 32'hDEADBEEF; such a write is dropped; `protocol_error` is set.
- States:
  - IDLE: request acceptance only happens here.
  - WAIT: counting down latency.
  - RESPOND: single cycle with `ram_data_valid` = 1; always returns to IDLE on the next edge.
- Accept (IDLE, `ram_rd` or `ram_wr` high at edge T):
  - Latch the request kind and address.
  - Load the counter with LAT-1 and go to WAIT. LAT is READ_LATENCY or WRITE_LATENCY.
  - LAT=1 goes directly to RESPOND.
  - `ram_data_valid` is high in the cycle following edge T+LAT-1, i.e. LAT cycles after the accept edge.
- Write commit:
  - The memory word is written at the accept edge T with `ram_data_wr`.
  - No byte enables; a full word is written.
- Read data:
  - The memory word is read in the edge before RESPOND and registered into `ram_data_rd`.
  - `ram_data_rd` holds its value until the next read response.
  - Write responses leave `ram_data_rd` unchanged.
- Back-to-back operation:
  - A request presented in the cycle immediately after RESPOND is seen in IDLE and accepted.
  - This matches the cache driving `ram_rd`/`ram_wr` from `ram_data_valid`.
  - Read-after-write to the same word returns the new data, because the write commits at accept.
- `ram_rd` and `ram_wr` both high in IDLE:
  - The write is performed and acknowledged with WRITE_LATENCY.
  - The read is dropped and `protocol_error` is set.
- Request while in WAIT or RESPOND: ignored (no effect on memory or timing); `protocol_error` is set.
- `protocol_error` clears only on `rst`.
- Reset mid-operation: the pending acknowledge is cancelled (`ram_data_valid` is 0 from the first reset cycle). A write already committed stays in memory.
- Counter width is $clog2 of the maximum latency plus 1 (including jitter); no wrap is permitted.

Optional Feature:
- Macro: RAM_RANDOM_LATENCY_EN.
- Defined:
  - Adds an 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded 8'hA5 on reset.
  - The LFSR advances once per accepted request.
  - Effective latency = base latency + LFSR[1:0] (0–3 extra cycles), sampled at accept.
  - Exercises cache wait handling.
- Undefined: latency is exactly READ_LATENCY / WRITE_LATENCY, and no LFSR logic is present.

Test Plan:
- Reset, then write pulse addr 16'h0010, data 32'h1234_5678 (WRITE_LATENCY=2) → `ram_data_valid` pulses exactly 2 cycles after accept, for 1 cycle; `ram_data_rd` stays 0.
- Read pulse addr 16'h0010 (READ_LATENCY=4) → `ram_data_valid` 4 cycles after accept with `ram_data_rd` = 32'h1234_5678. A read of addr 16'h0013 returns the same word.
- Cache-style 4-word burst: writes to 16'h0020..16'h002C, each issued the cycle after the previous valid, then reads of the same addresses → 4 acks spaced LAT+1 cycles apart, data returned in order, no `protocol_error`.
- Extra `ram_rd` pulse 2 cycles into a pending read → ignored; original ack timing unchanged; `protocol_error` = 1 until `rst`.
- `ram_rd` and `ram_wr` both high in IDLE with addr 16'h0040, data 32'hCAFE_F00D → write ack after WRITE_LATENCY; `protocol_error` = 1; a later read of 16'h0040 returns 32'hCAFE_F00D.
- Assert `rst` for 1 cycle while in WAIT of a read → no `ram_data_valid`; outputs return to 0; a new request is accepted on the first cycle after reset.
